// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the two-port block RAM arbiter: FSM state encoding and port IDs.
package ram_port_arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to rr_ptr.
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic       winner,
  output logic       any_valid
);

  assign any_valid = |valid;
  assign winner    = (valid == 2'b11) ? rr_ptr : (valid[1] ? PORT_AUX : PORT_CPU);

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises cpu/aux accesses onto one single-port block RAM, one transaction at a time,
// returning a registered one-cycle response to whichever port owned the transaction.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_valid,
  input  logic              aux_write,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ready,
  output logic              aux_rsp_valid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              grant_id
);

  // WAIT lasts RD_LATENCY-1 cycles; the counter is loaded with one less than that.
  localparam logic [1:0] WAIT_LOAD = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  logic [1:0] state;
  logic [1:0] wait_cnt;
  logic       write_flag;
  logic       rr_ptr;
  logic       winner;
  logic       any_valid;
  logic       accept;

  rr_arbiter2 u_rr_arbiter2 (
    .valid     ({aux_valid, cpu_valid}),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign accept    = (state == IDLE) && any_valid;
  assign cpu_ready = accept && (winner == PORT_CPU);
  assign aux_ready = accept && (winner == PORT_AUX);
  assign ram_write = (state == ACCESS) && write_flag;
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 2'd0;
      write_flag    <= 1'b0;
      rr_ptr        <= PORT_CPU;
      grant_id      <= PORT_CPU;
      ram_address   <= '0;
      ram_data_in   <= '0;
      cpu_rsp_valid <= 1'b0;
      aux_rsp_valid <= 1'b0;
      cpu_rdata     <= '0;
      aux_rdata     <= '0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      aux_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id    <= winner;
            rr_ptr      <= ~winner;
            ram_address <= (winner == PORT_AUX) ? aux_addr  : cpu_addr;
            ram_data_in <= (winner == PORT_AUX) ? aux_wdata : cpu_wdata;
            write_flag  <= (winner == PORT_AUX) ? aux_write : cpu_write;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (write_flag) begin
            // Writes complete as soon as the RAM has sampled the write strobe.
            if (grant_id == PORT_AUX) aux_rsp_valid <= 1'b1;
            else                      cpu_rsp_valid <= 1'b1;
            state <= IDLE;
          end else if (RD_LATENCY > 1) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end else begin
            state <= CAPTURE;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) state <= CAPTURE;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        CAPTURE: begin
          if (grant_id == PORT_AUX) begin
            aux_rdata     <= ram_data_out;
            aux_rsp_valid <= 1'b1;
          end else begin
            cpu_rdata     <= ram_data_out;
            cpu_rsp_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: one arbiter at RD_LATENCY=1 and one at RD_LATENCY=3, each with a behavioural RAM.
module tb_ram_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: RD_LATENCY=1
  logic       a_cpu_valid = 0, a_cpu_write = 0, a_aux_valid = 0, a_aux_write = 0;
  logic [7:0] a_cpu_addr = 0, a_cpu_wdata = 0, a_aux_addr = 0, a_aux_wdata = 0;
  logic       a_cpu_ready, a_cpu_rsp_valid, a_aux_ready, a_aux_rsp_valid;
  logic [7:0] a_cpu_rdata, a_aux_rdata, a_ram_address, a_ram_data_in, a_ram_data_out;
  logic       a_ram_write, a_busy, a_grant_id;

  // Instance B: RD_LATENCY=3
  logic       b_cpu_valid = 0, b_cpu_write = 0, b_aux_valid = 0, b_aux_write = 0;
  logic [7:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_aux_addr = 0, b_aux_wdata = 0;
  logic       b_cpu_ready, b_cpu_rsp_valid, b_aux_ready, b_aux_rsp_valid;
  logic [7:0] b_cpu_rdata, b_aux_rdata, b_ram_address, b_ram_data_in, b_ram_data_out;
  logic       b_ram_write, b_busy, b_grant_id;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset),
    .cpu_valid(a_cpu_valid), .cpu_write(a_cpu_write), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ready(a_cpu_ready), .cpu_rsp_valid(a_cpu_rsp_valid), .cpu_rdata(a_cpu_rdata),
    .aux_valid(a_aux_valid), .aux_write(a_aux_write), .aux_addr(a_aux_addr), .aux_wdata(a_aux_wdata),
    .aux_ready(a_aux_ready), .aux_rsp_valid(a_aux_rsp_valid), .aux_rdata(a_aux_rdata),
    .ram_address(a_ram_address), .ram_data_in(a_ram_data_in), .ram_write(a_ram_write),
    .ram_data_out(a_ram_data_out), .busy(a_busy), .grant_id(a_grant_id)
  );

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset),
    .cpu_valid(b_cpu_valid), .cpu_write(b_cpu_write), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ready(b_cpu_ready), .cpu_rsp_valid(b_cpu_rsp_valid), .cpu_rdata(b_cpu_rdata),
    .aux_valid(b_aux_valid), .aux_write(b_aux_write), .aux_addr(b_aux_addr), .aux_wdata(b_aux_wdata),
    .aux_ready(b_aux_ready), .aux_rsp_valid(b_aux_rsp_valid), .aux_rdata(b_aux_rdata),
    .ram_address(b_ram_address), .ram_data_in(b_ram_data_in), .ram_write(b_ram_write),
    .ram_data_out(b_ram_data_out), .busy(b_busy), .grant_id(b_grant_id)
  );

  // Behavioural block RAMs, read-first, with 1 and 3 cycles of output latency.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] pipe_b [3];

  always @(posedge clock) begin
    if (a_ram_write) mem_a[a_ram_address] <= a_ram_data_in;
    a_ram_data_out <= mem_a[a_ram_address];
  end

  always @(posedge clock) begin
    if (b_ram_write) mem_b[b_ram_address] <= b_ram_data_in;
    pipe_b[0] <= mem_b[b_ram_address];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_ram_data_out = pipe_b[2];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[8'h10] = 8'hA5;
    mem_a[8'h01] = 8'h11;
    mem_a[8'h02] = 8'h22;
    mem_b[8'h40] = 8'h5A;
    mem_b[8'h41] = 8'h77;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", a_busy, 0);
    check("rst_ram_address", a_ram_address, 0);
    check("rst_ram_data_in", a_ram_data_in, 0);
    check("rst_ram_write", a_ram_write, 0);
    check("rst_grant_id", a_grant_id, 0);
    check("rst_rsp", {a_cpu_rsp_valid, a_aux_rsp_valid, a_cpu_ready, a_aux_ready}, 0);
    check("rst_rdata", {a_cpu_rdata, a_aux_rdata}, 0);
    reset = 1'b0;
    tick();

    // Single cpu read of 0x10, RD_LATENCY=1
    a_cpu_valid = 1; a_cpu_write = 0; a_cpu_addr = 8'h10;
    #1;
    check("rd_cpu_ready_c0", a_cpu_ready, 1);
    check("rd_ram_write_c0", a_ram_write, 0);
    tick();
    a_cpu_valid = 0;
    check("rd_busy_c1", a_busy, 1);
    check("rd_ram_address_c1", a_ram_address, 8'h10);
    check("rd_ram_write_c1", a_ram_write, 0);
    tick();
    check("rd_ram_write_c2", a_ram_write, 0);
    check("rd_rsp_early_c2", a_cpu_rsp_valid, 0);
    tick();
    check("rd_cpu_rsp_valid_c3", a_cpu_rsp_valid, 1);
    check("rd_cpu_rdata_c3", a_cpu_rdata, 8'hA5);
    check("rd_aux_unchanged_c3", {a_aux_rsp_valid, a_aux_rdata}, 0);
    tick();
    check("rd_rsp_one_cycle_c4", a_cpu_rsp_valid, 0);

    // Aux write 0x3C to 0x20, then aux read back
    a_aux_valid = 1; a_aux_write = 1; a_aux_addr = 8'h20; a_aux_wdata = 8'h3C;
    #1;
    check("wr_aux_ready_c0", a_aux_ready, 1);
    tick();
    a_aux_valid = 0; a_aux_write = 0;
    check("wr_ram_write_c1", a_ram_write, 1);
    check("wr_ram_address_c1", a_ram_address, 8'h20);
    check("wr_ram_data_in_c1", a_ram_data_in, 8'h3C);
    check("wr_grant_id_c1", a_grant_id, 1);
    tick();
    check("wr_ram_write_c2", a_ram_write, 0);
    check("wr_aux_rsp_valid_c2", a_aux_rsp_valid, 1);
    check("wr_cpu_untouched_c2", {a_cpu_rsp_valid, a_cpu_rdata}, {1'b0, 8'hA5});
    a_aux_valid = 1; a_aux_addr = 8'h20;
    #1;
    check("rb_aux_ready", a_aux_ready, 1);
    tick();
    a_aux_valid = 0;
    tick();
    tick();
    check("rb_aux_rsp_valid", a_aux_rsp_valid, 1);
    check("rb_aux_rdata", a_aux_rdata, 8'h3C);

    // Contention from reset: both ports hold reads, grants must alternate from cpu
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    a_cpu_valid = 1; a_cpu_addr = 8'h01;
    a_aux_valid = 1; a_aux_addr = 8'h02;
    #1;
    for (int t = 0; t < 4; t++) begin
      logic exp_port;
      exp_port = t[0];
      check("cont_cpu_ready", a_cpu_ready, !exp_port);
      check("cont_aux_ready", a_aux_ready, exp_port);
      tick();
      check("cont_grant_id", a_grant_id, exp_port);
      tick();
      tick();
      if (exp_port == 1'b0) begin
        check("cont_cpu_rsp", {a_cpu_rsp_valid, a_aux_rsp_valid}, 2'b10);
        check("cont_cpu_rdata", a_cpu_rdata, 8'h11);
      end else begin
        check("cont_aux_rsp", {a_cpu_rsp_valid, a_aux_rsp_valid}, 2'b01);
        check("cont_aux_rdata", a_aux_rdata, 8'h22);
      end
      if (t == 3) begin
        a_cpu_valid = 0;
        a_aux_valid = 0;
      end
    end
    tick();
    check("cont_idle_after", a_busy, 0);

    // Latency sweep on RD_LATENCY=3
    b_cpu_valid = 1; b_cpu_addr = 8'h40;
    #1;
    check("lat3_cpu_ready_c0", b_cpu_ready, 1);
    tick();
    b_cpu_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      check("lat3_ram_address_stable", b_ram_address, 8'h40);
      check("lat3_busy", b_busy, 1);
      check("lat3_no_early_rsp", b_cpu_rsp_valid, 0);
      tick();
    end
    check("lat3_cpu_rsp_valid_c5", b_cpu_rsp_valid, 1);
    check("lat3_cpu_rdata_c5", b_cpu_rdata, 8'h5A);
    tick();

    // Reset during WAIT drops the read and restores rr_ptr to cpu
    b_cpu_valid = 1; b_cpu_addr = 8'h41;
    tick();
    b_cpu_valid = 0;
    tick();
    check("rstw_in_wait_busy", b_busy, 1);
    reset = 1'b1;
    #1;
    check("rstw_busy", b_busy, 0);
    check("rstw_ram_address", b_ram_address, 0);
    check("rstw_grant_rdata", {b_grant_id, b_cpu_rdata, b_aux_rdata}, 0);
    check("rstw_rsp", {b_cpu_rsp_valid, b_aux_rsp_valid}, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rstw_no_rsp", {b_cpu_rsp_valid, b_aux_rsp_valid}, 0);
    end
    b_cpu_valid = 1; b_cpu_addr = 8'h40;
    b_aux_valid = 1; b_aux_addr = 8'h41;
    #1;
    check("rstw_cpu_first", {b_cpu_ready, b_aux_ready}, 2'b10);
    tick();
    b_cpu_valid = 0;
    b_aux_valid = 0;
    check("rstw_grant_cpu", b_grant_id, 0);
    for (int c = 0; c < 5; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
